// File: rtl/receptor_jogada.sv
// Play-capture unit: synchronizes and debounces the key switches, validates one-hot
// moves and enforces the per-move timeout window for the game FSM.
//
// state   | meaning
// OCIOSO  | idle; waiting for armar from the game FSM
// SOLTA   | armed, but a key from the previous move is still held
// AGUARDA | armed, keys released, waiting for a press
// FILTRA  | candidate value captured, counting stable samples
module receptor_jogada #(
  parameter int TIMEOUT_CICLOS = 3000,
  parameter int ESTAVEL_CICLOS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       armar,
  input  logic [3:0] chaves,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       jogada_invalida,
  output logic       timeout,
  output logic       aguardando,
  output logic [2:0] db_estado
);

  localparam int CT_W = $clog2(TIMEOUT_CICLOS + 1);
  localparam int CF_W = $clog2(ESTAVEL_CICLOS + 1);
  localparam logic [CT_W-1:0] CT_ULTIMO = CT_W'(TIMEOUT_CICLOS - 1);
  localparam logic [CF_W-1:0] CF_ALVO   = CF_W'(ESTAVEL_CICLOS);
  localparam logic [CT_W-1:0] CT_UM     = CT_W'(1);
  localparam logic [CF_W-1:0] CF_UM     = CF_W'(1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    SOLTA   = 3'd1,
    AGUARDA = 3'd2,
    FILTRA  = 3'd3
  } estado_t;

  estado_t         estado, prox;
  logic [3:0]      s1, s2;
  logic [3:0]      cand, cand_prox;
  logic [CT_W-1:0] ct, ct_prox;
  logic [CF_W-1:0] cf, cf_prox;
  logic [3:0]      jogada_prox;
  logic            feita_prox, invalida_prox, timeout_prox;
  logic            decidiu;
  logic            one_hot;
  logic            expira;

  // x & (x-1) clears the lowest set bit; zero result with x != 0 means one-hot.
  assign one_hot = (cand != 4'b0000) && ((cand & (cand - 4'd1)) == 4'b0000);
  assign expira  = (ct == CT_ULTIMO);

  always_ff @(posedge clock) begin
    if (reset) begin
      s1              <= 4'b0000;
      s2              <= 4'b0000;
      estado          <= OCIOSO;
      ct              <= '0;
      cf              <= '0;
      cand            <= 4'b0000;
      jogada          <= 4'b0000;
      jogada_feita    <= 1'b0;
      jogada_invalida <= 1'b0;
      timeout         <= 1'b0;
      aguardando      <= 1'b0;
      db_estado       <= 3'd0;
    end else begin
      s1              <= chaves;
      s2              <= s1;
      estado          <= prox;
      ct              <= ct_prox;
      cf              <= cf_prox;
      cand            <= cand_prox;
      jogada          <= jogada_prox;
      jogada_feita    <= feita_prox;
      jogada_invalida <= invalida_prox;
      timeout         <= timeout_prox;
      aguardando      <= (prox != OCIOSO);
      db_estado       <= prox;
    end
  end

  always_comb begin
    prox          = estado;
    ct_prox       = ct;
    cf_prox       = cf;
    cand_prox     = cand;
    jogada_prox   = jogada;
    feita_prox    = 1'b0;
    invalida_prox = 1'b0;
    timeout_prox  = 1'b0;
    decidiu       = 1'b0;

    if (estado != OCIOSO) begin
      ct_prox = ct + CT_UM;
    end

    unique case (estado)
      OCIOSO: begin
        if (armar) begin
          ct_prox = '0;
          prox    = (s2 == 4'b0000) ? AGUARDA : SOLTA;
        end
      end
      SOLTA: begin
        if (s2 == 4'b0000) begin
          prox = AGUARDA;
        end
      end
      AGUARDA: begin
        if (s2 != 4'b0000) begin
          cand_prox = s2;
          cf_prox   = CF_UM;
          prox      = FILTRA;
        end
      end
      FILTRA: begin
        if (s2 != cand) begin
          prox = AGUARDA;
        end else if (cf == CF_ALVO) begin
          decidiu = 1'b1;
          prox    = OCIOSO;
          if (one_hot) begin
            jogada_prox = cand;
            feita_prox  = 1'b1;
          end else begin
            invalida_prox = 1'b1;
          end
        end else begin
          cf_prox = cf + CF_UM;
        end
      end
      default: begin
        prox = OCIOSO;
      end
    endcase

    // A decision on the expiry edge takes priority over the timeout.
    if ((estado != OCIOSO) && expira && !decidiu) begin
      timeout_prox = 1'b1;
      prox         = OCIOSO;
    end
  end

endmodule

// File: tb/tb_receptor_jogada.sv
// Bench for receptor_jogada: table of single moves plus hand-written corner sequences;
// expected pulses go into a queue and are matched against DUT pulses by a monitor.
module tb_receptor_jogada;

  localparam int T = 3000;
  localparam int E = 2;
  localparam logic [2:0] K_FEITA = 3'b001;
  localparam logic [2:0] K_INV   = 3'b010;
  localparam logic [2:0] K_TO    = 3'b100;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       armar = 1'b0;
  logic [3:0] chaves = 4'b0000;
  logic [3:0] jogada;
  logic       jogada_feita, jogada_invalida, timeout, aguardando;
  logic [2:0] db_estado;

  receptor_jogada #(.TIMEOUT_CICLOS(T), .ESTAVEL_CICLOS(E)) dut (
    .clock(clock),
    .reset(reset),
    .armar(armar),
    .chaves(chaves),
    .jogada(jogada),
    .jogada_feita(jogada_feita),
    .jogada_invalida(jogada_invalida),
    .timeout(timeout),
    .aguardando(aguardando),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int edges = 0;
  always @(posedge clock) edges <= edges + 1;

  typedef struct {
    logic [2:0] kind;
    logic [3:0] jog;
    int         at;
  } ev_t;

  typedef struct {
    logic [3:0] key;
    int         hold;
    logic [2:0] kind;
    logic [3:0] jog;
  } vec_t;

  ev_t  sb[$];
  vec_t tab[7];
  int   checks = 0;
  int   errors = 0;
  int   base, a;

  task automatic check(input string nome, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (edge %0d)", nome, act, exp, edges);
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic armar_jogada(input int est_exp);
    armar = 1'b1;
    @(negedge clock);
    armar = 1'b0;
    check("arm_aguardando", aguardando, 1);
    check("arm_estado", db_estado, est_exp);
  endtask

  task automatic pressiona(input logic [3:0] key, input logic [3:0] jog_exp);
    base   = edges;
    chaves = key;
    sb.push_back(ev_t'{K_FEITA, jog_exp, base + 5});
    ciclos(5);
    chaves = 4'b0000;
    ciclos(6);
    check("press_sb_vazio", sb.size(), 0);
    check("press_jogada", jogada, jog_exp);
    check("press_estado", db_estado, 0);
  endtask

  // Pulse monitor: every pulse must match the head of the queue, kind, edge and jogada.
  always @(negedge clock) begin : monitor
    logic [2:0] p;
    ev_t        e;
    p = {timeout, jogada_invalida, jogada_feita};
    if (p != 3'b000) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", p, 0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", p, e.kind);
        check("pulse_edge", edges, e.at);
        check("pulse_jogada", jogada, e.jog);
      end
    end
  end

  initial begin
    tab[0] = vec_t'{4'b0001, 5, K_FEITA, 4'b0001};
    tab[1] = vec_t'{4'b0010, 5, K_FEITA, 4'b0010};
    tab[2] = vec_t'{4'b0100, 5, K_FEITA, 4'b0100};
    tab[3] = vec_t'{4'b0011, 5, K_INV,   4'b0100};
    tab[4] = vec_t'{4'b1000, 5, K_FEITA, 4'b1000};
    tab[5] = vec_t'{4'b1111, 5, K_INV,   4'b1000};
    tab[6] = vec_t'{4'b0001, 3, K_FEITA, 4'b0001};

    @(negedge clock);
    reset = 1'b1;
    ciclos(10);
    check("rst_jogada", jogada, 0);
    check("rst_pulsos", {timeout, jogada_invalida, jogada_feita}, 0);
    check("rst_aguardando", aguardando, 0);
    check("rst_estado", db_estado, 0);
    reset = 1'b0;
    ciclos(2);

    for (int i = 0; i < 7; i++) begin
      armar_jogada(2);
      base   = edges;
      chaves = tab[i].key;
      sb.push_back(ev_t'{tab[i].kind, tab[i].jog, base + 5});
      ciclos(tab[i].hold);
      chaves = 4'b0000;
      ciclos(6);
      check("vec_sb_vazio", sb.size(), 0);
      check("vec_jogada", jogada, tab[i].jog);
      check("vec_aguardando", aguardando, 0);
      check("vec_estado", db_estado, 0);
    end

    // Single-cycle glitch returns to AGUARDA silently; a real press then completes.
    armar_jogada(2);
    chaves = 4'b1000;
    ciclos(1);
    chaves = 4'b0000;
    ciclos(4);
    check("glitch_estado", db_estado, 2);
    check("glitch_aguardando", aguardando, 1);
    pressiona(4'b0010, 4'b0010);

    // Timeout with no press, then a late press is ignored.
    armar_jogada(2);
    a = edges;
    sb.push_back(ev_t'{K_TO, 4'b0010, a + T});
    while (edges < a + T + 5) @(negedge clock);
    check("to_sb_vazio", sb.size(), 0);
    check("to_estado", db_estado, 0);
    check("to_aguardando", aguardando, 0);
    check("to_jogada", jogada, 4'b0010);
    chaves = 4'b0100;
    ciclos(10);
    chaves = 4'b0000;
    ciclos(5);
    check("late_estado", db_estado, 0);
    check("late_jogada", jogada, 4'b0010);

    // Arm with key still held: wait in SOLTA until release.
    chaves = 4'b0001;
    ciclos(3);
    armar_jogada(1);
    ciclos(10);
    check("solta_estado", db_estado, 1);
    check("solta_aguardando", aguardando, 1);
    chaves = 4'b0000;
    ciclos(3);
    check("solta_liberada", db_estado, 2);
    pressiona(4'b1000, 4'b1000);

    // Reset while filtering aborts without any pulse.
    armar_jogada(2);
    chaves = 4'b0100;
    ciclos(3);
    check("filtra_estado", db_estado, 3);
    reset = 1'b1;
    ciclos(1);
    check("rstf_jogada", jogada, 0);
    check("rstf_pulsos", {timeout, jogada_invalida, jogada_feita}, 0);
    check("rstf_aguardando", aguardando, 0);
    check("rstf_estado", db_estado, 0);
    chaves = 4'b0000;
    ciclos(3);
    reset = 1'b0;
    ciclos(3);

    // Decision landing exactly on the expiry edge wins over timeout.
    armar_jogada(2);
    a = edges;
    while (edges < a + T - 5) @(negedge clock);
    chaves = 4'b0001;
    sb.push_back(ev_t'{K_FEITA, 4'b0001, a + T});
    ciclos(5);
    chaves = 4'b0000;
    ciclos(8);
    check("race_sb_vazio", sb.size(), 0);
    check("race_jogada", jogada, 4'b0001);
    check("race_estado", db_estado, 0);

    // One edge later, the timeout wins and the move is dropped.
    armar_jogada(2);
    a = edges;
    while (edges < a + T - 4) @(negedge clock);
    chaves = 4'b0010;
    sb.push_back(ev_t'{K_TO, 4'b0001, a + T});
    ciclos(6);
    chaves = 4'b0000;
    ciclos(6);
    check("late_race_sb_vazio", sb.size(), 0);
    check("late_race_jogada", jogada, 4'b0001);
    check("late_race_estado", db_estado, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/receptor_jogada.md
# receptor_jogada

Play-capture unit for the memory game: it accepts one player move per request from the game FSM, filters and validates the 4-bit `chaves` input, and enforces the per-move timeout. It sits between the board switches and the game FSM. It is the receiving end of the move stream that the game testbenches drive: one one-hot key press, then release, per move.

## Interface

**Parameters**
- `TIMEOUT_CICLOS`, default 3000: clock cycles allowed per move after `armar`. At 1 kHz this is 3 s.
- `ESTAVEL_CICLOS`, default 2, minimum 1: consecutive synchronized samples a nonzero `chaves` value must hold before it is accepted.

**Ports**
- `clock` in 1: single clock; all state is updated on the rising edge.
- `reset` in 1: synchronous, active-high.
- `armar` in 1: request one move. Sampled only in OCIOSO.
- `chaves` in 4: raw switch inputs, asynchronous to `clock`.
- `jogada` out 4: last accepted move, held until the next accept or reset.
- `jogada_feita` out 1: one-cycle pulse when a valid move is accepted.
- `jogada_invalida` out 1: one-cycle pulse when a stable value is not one-hot.
- `timeout` out 1: one-cycle pulse when the move window expires.
- `aguardando` out 1: high in every state except OCIOSO.
- `db_estado` out 3: current state code.

## Operation

- `chaves` passes through a 2-flop synchronizer, giving `s2`. All decisions use `s2`.
- **OCIOSO (0):**
  - `armar=1` clears the timeout counter `ct`.
  - It then moves to AGUARDA if `s2==0`, else to SOLTA.
  - `armar` in any other state is ignored.
- **SOLTA (1):** a key is still held from the previous move. Go to AGUARDA when `s2==0`.
- **AGUARDA (2):** when `s2!=0`, latch `cand←s2`, set `cf←1` and go to FILTRA.
- **FILTRA (3):**
  - If `s2!=cand`: go back to AGUARDA. This is a glitch or a key change; `cand` is discarded.
  - Else if `cf==ESTAVEL_CICLOS`, the value is stable:
    - If `cand` is one-hot (exactly one bit set): `jogada←cand` and pulse `jogada_feita`.
    - Otherwise: pulse `jogada_invalida` and leave `jogada` unchanged.
    - In both cases go to OCIOSO.
  - Else increment `cf`.
- **Timeout:**
  - `ct` increments every cycle in SOLTA, AGUARDA and FILTRA.
  - On the edge where `ct==TIMEOUT_CICLOS-1` and no accept or invalid decision occurs, pulse `timeout` and go to OCIOSO.
  - If an accept or invalid decision and timeout expiry fall on the same edge, the decision wins and `timeout` stays 0.
- **Widths:**
  - `ct` is `$clog2(TIMEOUT_CICLOS+1)` bits. It never wraps, because leaving the armed states stops it.
  - `cf` is `$clog2(ESTAVEL_CICLOS+1)` bits.
- At most one of `jogada_feita`, `jogada_invalida` and `timeout` is high in any cycle.
- All outputs are registered.

## Timing

- **Reset:** the first edge with `reset=1` sets:
  - state = OCIOSO;
  - `jogada=4'b0000`;
  - `jogada_feita=jogada_invalida=timeout=0`;
  - `aguardando=0`, `db_estado=0`;
  - `ct`, `cf`, `cand` and both synchronizer flops = 0.
- Reset mid-move aborts the move without emitting any pulse.
- **Arm latency:** `aguardando` goes high in the cycle after the edge that samples `armar=1`.
- **Accept latency:** let a stable nonzero `chaves` be set up before edge k while in AGUARDA.
  - `s2` is valid after edge k+1.
  - FILTRA is entered at edge k+2.
  - The decision happens at edge k+2+`ESTAVEL_CICLOS`.
  - The pulse is visible in the cycle after that edge; with defaults, after edge k+4.
  - On that same edge, `jogada` updates and `aguardando` falls.
- **Timeout latency:** with `armar` sampled at edge a and no decision occurring, `timeout` is high in the cycle after edge a+`TIMEOUT_CICLOS`.
- **Pulse width:** every pulse is exactly one cycle wide, regardless of how long `chaves` is held.
- **Rearm:** a new `armar` is accepted on the edge immediately after a pulse cycle. If the key is still held, the move waits in SOLTA.

## Test plan

1. Reset 10 cycles, `armar` 1 cycle, then `chaves=0001` for 5 cycles -> `jogada_feita` pulse 4 cycles after `chaves` changes, `jogada=0001`, `aguardando=0` after the pulse, no `timeout`.
2. Back-to-back moves `0010` then `0100`, each held 5 cycles followed by 5 cycles at 0, with `armar` pulsed after each `jogada_feita` -> two single-cycle `jogada_feita` pulses, `jogada` goes `0010` then `0100`.
3. Arm, then keep `chaves=0` for 3100 cycles -> `timeout` pulse in the cycle after arm edge + 3000, state OCIOSO, `jogada` unchanged. A late press afterwards produces no pulse until the next `armar`.
4. Arm, then `chaves=0011` for 5 cycles -> `jogada_invalida` pulse, `jogada` unchanged. Glitch case: `chaves=1000` for 1 cycle then 0 -> no pulse, state returns to AGUARDA.
5. Arm while `chaves=0001` is still held -> stays in SOLTA with no pulse. Release, then `chaves=1000` -> `jogada=1000`.
6. Assert `reset` while in FILTRA -> next cycle all outputs 0 and `db_estado=0`. Press landing on the edge where `ct==TIMEOUT_CICLOS-1` -> `jogada_feita` only, `timeout` stays 0.
